// File: rtl/comp_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
// Holds the FSM state encoding, the result encoding and the cycles-width helper.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_EQ   = 2'd1,
    RES_GT   = 2'd2,
    RES_LT   = 2'd3
  } result_t;

  // Width needed to hold a chunk count in the range 0..nchunk.
  function automatic int cycles_width(input int nchunk);
    return $clog2(nchunk + 1);
  endfunction

endpackage

// File: rtl/comp_chunk.sv
// Combinational CHUNK-bit unsigned magnitude compare.
// The caller applies any sign flip before presenting x and y.
module comp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             gt,
  output logic             lt
);

  assign gt = (x > y);
  assign lt = (x < y);

endmodule

// File: rtl/comp_serial.sv
// Serial MSB-first magnitude comparator with early termination.
// Operands are shifted left CHUNK bits per cycle; the top chunk feeds comp_chunk.
module comp_serial
  import comp_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int CHUNK  = 4,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW     = cycles_width(NCHUNK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [CW-1:0]    cycles
);

  state_t           state, next_state;
  result_t          result;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             smode;
  logic [CW-1:0]    cnt, cnt_inc, cycles_q;
  logic [CHUNK-1:0] xa, xb;
  logic             c_gt, c_lt, last;

  // Flipping the sign bit of the leading chunk maps two's-complement order onto unsigned order.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    xa = a_sh[WIDTH-1 -: CHUNK];
    xb = b_sh[WIDTH-1 -: CHUNK];
    if (smode && (cnt == '0)) begin
      xa[CHUNK-1] = ~xa[CHUNK-1];
      xb[CHUNK-1] = ~xb[CHUNK-1];
    end
  end

  assign cnt_inc = cnt + CW'(1);
  assign last    = (cnt_inc == CW'(NCHUNK));

  comp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x  (xa),
    .y  (xb),
    .gt (c_gt),
    .lt (c_lt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (in_valid) next_state = CMP;
      CMP:     if (c_gt || c_lt || last) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decode from state only
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: operand shifters, chunk counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      smode    <= 1'b0;
      cnt      <= '0;
      result   <= RES_NONE;
      cycles_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            smode <= signed_mode;
            cnt   <= '0;
          end
        end
        CMP: begin
          cnt <= cnt_inc;
          if (c_gt) begin
            result   <= RES_GT;
            cycles_q <= cnt_inc;
          end else if (c_lt) begin
            result   <= RES_LT;
            cycles_q <= cnt_inc;
          end else if (last) begin
            result   <= RES_EQ;
            cycles_q <= cnt_inc;
          end else begin
            a_sh <= a_sh << CHUNK;
            b_sh <= b_sh << CHUNK;
          end
        end
        DONE: begin
          if (out_ready) result <= RES_NONE;
        end
        default: ;
      endcase
    end
  end

  assign eq     = (result == RES_EQ);
  assign gt     = (result == RES_GT);
  assign lt     = (result == RES_LT);
  assign cycles = cycles_q;

endmodule

// File: tb/tb_comp_serial.sv
// Randomized self-checking bench for comp_serial (WIDTH=16, CHUNK=4).
// Expected results come from integer comparison and an XOR scan for the first differing chunk.
module tb_comp_serial;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             eq, gt, lt;
  logic [CW-1:0]    cycles;

  int compared   = 0;
  int mismatched = 0;

  comp_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .eq          (eq),
    .gt          (gt),
    .lt          (lt),
    .cycles      (cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {eq,gt,lt} from integer compare, k = 1-based index of first differing chunk.
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic ms,
                       output logic [2:0] flags, output int k);
    logic signed [WIDTH-1:0] sa, sb;
    logic [WIDTH-1:0] diff;
    sa = ma;
    sb = mb;
    if (ms) flags = {sa == sb, sa > sb, sa < sb};
    else    flags = {ma == mb, ma > mb, ma < mb};
    diff = ma ^ mb;
    k = NCHUNK;
    for (int i = 0; i < NCHUNK; i++) begin
      if (((diff >> (WIDTH - CHUNK * (i + 1))) & ((1 << CHUNK) - 1)) != 0) begin
        k = i + 1;
        break;
      end
    end
  endtask

  // Drive operands until accepted; returns #1 after the acceptance edge.
  task automatic accept(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic ts);
    int guard = 0;
    while (!in_ready && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_ready", in_ready, 1'b1);
    a = ta; b = tb_; signed_mode = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_accept", in_ready, 1'b0);
  endtask

  // Measure latency from acceptance edge and check the result fields.
  task automatic wait_result(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic ts,
                             input string tag);
    logic [2:0] ef;
    int ek, n;
    model(ta, tb_, ts, ef, ek);
    n = 1;
    while (!out_valid && n <= 2 * NCHUNK + 4) begin
      @(posedge clk); #1;
      if (!out_valid) n++;
    end
    if (!out_valid) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_latency"}, n, ek);
    check({tag, "_flags"}, {eq, gt, lt}, ef);
    check({tag, "_cycles"}, cycles, ek);
  endtask

  // Hold out_ready low for `hold` cycles, checking stability, then complete the handshake.
  task automatic finish(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic ts,
                        input int hold, input string tag);
    logic [2:0] ef;
    int ek;
    model(ta, tb_, ts, ef, ek);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_flags"}, {eq, gt, lt}, ef);
      check({tag, "_hold_cycles"}, cycles, ek);
      check({tag, "_hold_inready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, out_valid, 1'b0);
    check({tag, "_post_flags"}, {eq, gt, lt}, 3'b000);
  endtask

  task automatic txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic ts,
                     input int hold, input string tag);
    accept(ta, tb_, ts);
    wait_result(ta, tb_, ts, tag);
    finish(ta, tb_, ts, hold, tag);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic rs;
    int h1, a2, nacc;
    bit acc, hs, switched;
    logic [2:0] ef;
    int ek;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; signed_mode = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_flags", {eq, gt, lt}, 3'b000);
    check("rst_cycles", cycles, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    txn(16'h1234, 16'h1234, 1'b0, 0, "equal");
    txn(16'h8000, 16'h7FFF, 1'b0, 1, "uns_sign");
    txn(16'h8000, 16'h7FFF, 1'b1, 1, "sgn_sign");
    txn(16'h12F0, 16'h12E0, 1'b0, 0, "late_gt");
    txn(16'hFFFE, 16'hFFFF, 1'b1, 0, "late_lt");

    // Backpressure with a competing request that must wait for the handshake.
    accept(16'h00A0, 16'h0050, 1'b0);
    wait_result(16'h00A0, 16'h0050, 1'b0, "bp");
    a = 16'h0003; b = 16'h0003; signed_mode = 1'b1; in_valid = 1'b1;
    model(16'h00A0, 16'h0050, 1'b0, ef, ek);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1'b1);
      check("bp_flags", {eq, gt, lt}, ef);
      check("bp_cycles", cycles, ek);
      check("bp_inready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_hs_valid", out_valid, 1'b0);
    check("bp_hs_inready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_accepted", in_ready, 1'b0);
    wait_result(16'h0003, 16'h0003, 1'b1, "bp2");
    finish(16'h0003, 16'h0003, 1'b1, 0, "bp2");

    // Reset during CMP aborts the transaction.
    accept(16'h1234, 16'h1234, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 1'b0);
    check("abort_inready", in_ready, 1'b1);
    check("abort_flags", {eq, gt, lt}, 3'b000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_result", out_valid, 1'b0);
      check("abort_idle", in_ready, 1'b1);
    end
    txn(16'h0001, 16'h0002, 1'b0, 0, "after_abort");

    // Back-to-back: in_valid held, out_ready held; second accept one cycle after first handshake.
    model(16'h00FF, 16'h0F00, 1'b0, ef, ek);
    a = 16'h00FF; b = 16'h0F00; signed_mode = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    h1 = -1; a2 = -1; nacc = 0; switched = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs && h1 < 0) begin
        h1 = cyc;
        check("b2b_first_flags", {eq, gt, lt}, ef);
        check("b2b_first_cycles", cycles, ek);
      end
      if (acc) begin
        nacc++;
        if (nacc == 2) a2 = cyc;
      end
      @(posedge clk); #1;
      if (acc && !switched) begin
        a = 16'hABCD; b = 16'hABCD; signed_mode = 1'b1;
        switched = 1'b1;
      end else if (acc) begin
        in_valid = 1'b0;
        break;
      end
    end
    out_ready = 1'b0;
    check("b2b_seen_handshake", (h1 >= 0), 1'b1);
    check("b2b_accept_gap", a2 - h1, 1);
    wait_result(16'hABCD, 16'hABCD, 1'b1, "b2b_second");
    finish(16'hABCD, 16'hABCD, 1'b1, 0, "b2b_second");

    // Random transactions biased toward shared leading chunks.
    for (int t = 0; t < 40; t++) begin
      ra = WIDTH'($urandom);
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = WIDTH'($urandom);
        2:       rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        default: rb = ra ^ WIDTH'($urandom_range(1, (1 << CHUNK) - 1));
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      txn(ra, rb, rs, $urandom_range(0, 2), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
